// File: rtl/iob_mem_reader.sv
// IOb bus initiator: reads len consecutive 32-bit words starting at base_addr and
// streams them out in order; credit-limited so the internal FIFO never overflows.
module iob_mem_reader #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int FIFO_AW = 2
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                m_avalid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   tdata_o,
  output logic                tvalid_o,
  output logic                tlast_o,
  input  logic                tready_i
);

  localparam int D  = 2 ** FIFO_AW;
  localparam int CW = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    req_left;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    beat;
  logic [LEN_W-1:0]    last_idx;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       count;
  logic [CW:0]         inflight;
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [DATA_W-1:0]   mem [D];
  logic                credit_ok;
  logic                grant;
  logic                push;
  logic                pop;
  logic                last_pop;
  logic                start_ok;

  // Only grants raise outstanding+count (pushes just move a word from one to the
  // other), so once a request is offered the credit check cannot retract it.
  assign inflight   = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok  = inflight < (CW + 1)'(D);
  assign m_avalid_o = (state == REQ) && (req_left != '0) && credit_ok;
  assign m_addr_o   = addr;
  assign m_wdata_o  = '0;
  assign m_wstrb_o  = '0;

  assign grant    = m_avalid_o & m_ready_i;
  assign push     = m_rvalid_i & (outstanding != '0);
  assign tvalid_o = (count != '0);
  assign pop      = tvalid_o & tready_i;
  assign last_idx = len_r - LEN_W'(1);
  assign last_pop = pop & (beat == last_idx);
  assign tdata_o  = mem[rd_ptr];
  assign tlast_o  = tvalid_o & (beat == last_idx);
  assign start_ok = (state == IDLE) & start_i;
  assign busy_o   = (state == REQ) || (state == DRAIN);
  assign done_o   = (state == FIN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_i) state_nxt = (len_i == '0) ? FIN : REQ;
      REQ:   if (grant && (req_left == LEN_W'(1))) state_nxt = DRAIN;
      DRAIN: if (last_pop) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state       <= IDLE;
      addr        <= '0;
      req_left    <= '0;
      len_r       <= '0;
      beat        <= '0;
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int unsigned i = 0; i < D; i++) mem[i] <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      if (start_ok) begin
        addr     <= base_addr_i & ~ADDR_W'(3);
        req_left <= len_i;
        len_r    <= len_i;
        beat     <= '0;
      end else begin
        if (grant) begin
          addr     <= addr + ADDR_W'(4);
          req_left <= req_left - LEN_W'(1);
        end
        if (pop) beat <= beat + LEN_W'(1);
      end
      unique case ({grant, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) begin
        mem[wr_ptr] <= m_rdata_i;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
    end
  end

endmodule
